dp_arbiter: RTL and testbench
=============================

Name: dp_arbiter

Overview:
Shares the single 4-register ALU datapath between two micro-op sequencer FSMs (requester 0 and requester 1). Each requester drives {opcode, operand1, operand2} and reads ZERO_FLAG back through this block. A requester owns the datapath for a whole program, so register contents are never interleaved. The block sits between the sequencers and the datapath, does round-robin arbitration, inserts a NOP flush cycle on every hand-over, and has a hold-time watchdog.

Parameters:
TIMEOUT, 64, maximum cycles one owner may hold the datapath (1..65535; 0 disables watchdog)
OPC_W, 3, opcode width
REG_W, 2, register-address width of operand1/operand2

Ports:
CLK  input  1  clock, rising edge
RST  input  1  reset, asynchronous, active-high
REQ0, REQ1  input  1 each  requester wants or holds the datapath; level, held for the whole program
DONE0, DONE1  input  1 each  requester finished; releases ownership
OPC0, OPC1  input  OPC_W each  requester opcode
OPA0, OPA1  input  REG_W each  requester operand1
OPB0, OPB1  input  REG_W each  requester operand2
ZERO_FLAG  input  1  zero flag from the datapath
GNT0, GNT1  output  1 each  ownership grant; one-hot or zero
ZF0, ZF1  output  1 each  ZERO_FLAG routed to the owner only
opcode  output  OPC_W  to datapath
operand1, operand2  output  REG_W each  to datapath
BUSY  output  1  a requester currently owns the datapath
ABORT  output  1  one-cycle pulse when the watchdog revokes a grant

Behaviour:
- Reset (async, RST=1): state=IDLE, LAST=1 (requester 0 wins first contention), hold counter=0. GNT0/1=0, ZF0/1=0, BUSY=0, ABORT=0, opcode=NOP (all zeros), operands=0. Reset mid-ownership drops the grant immediately, without waiting for a clock edge.
- States: IDLE, OWN0, OWN1, REL. State is registered. GNTx, BUSY and ABORT are registered decodes.
- IDLE/REL arbitration, at each clock edge:
  - Only REQx=1: go to OWNx.
  - Both set: go to OWN of the requester != LAST.
  - Neither set: go to or stay in IDLE.
  - Latency: REQ sampled at edge N; GNT high from edge N onward.
  - DONEx is ignored while not owned.
- OWNx:
  - opcode/operand1/operand2 = OPCx/OPAx/OPBx, combinational pass-through with zero added latency.
  - ZFx=ZERO_FLAG; the non-owner ZF=0.
  - REQ from the non-owner is ignored and stays pending.
- Release, evaluated in OWNx at each edge:
  - DONEx=1 or REQx=0: go to REL and set LAST<=x.
  - Else if TIMEOUT!=0 and counter==TIMEOUT-1: go to REL, set LAST<=x, ABORT=1 for exactly the REL cycle.
  - DONE and timeout in the same cycle count as a normal release; ABORT stays 0.
- REL:
  - One cycle, GNT0/1=0, BUSY=0, opcode=NOP, operands=0, ZF0/1=0.
  - Arbitrates like IDLE, so a waiting requester is granted at the end of REL. The minimum hand-over gap is one NOP cycle.
- Hold counter: 16 bits. Cleared on entry to OWNx, incremented each cycle in OWNx, saturates at its maximum, held at 0 outside OWN states.
- Re-grant after abort: the aborted requester may be re-granted only after the other requester is served, or immediately if the other is not requesting.
- Outside OWNx: datapath outputs are NOP/0. Datapath outputs never show a mix of OPC0 and OPC1 fields.

Test Plan:
- Reset then REQ0=1 only, OPC0=3'b100, OPA0=2'b11, OPB0=2'b00 -> GNT0=1 one edge later, opcode=100, operand1=11, operand2=00, BUSY=1, ZF0 follows ZERO_FLAG, ZF1=0.
- REQ0 and REQ1 rise in the same cycle after reset -> GNT0 first. DONE0 pulse -> one REL cycle with opcode=000, then GNT1=1 and LAST=0. Both re-requesting next -> GNT0 after REQ1 releases (alternation holds).
- TIMEOUT=8, REQ1 held with no DONE1 -> GNT1 high for exactly 8 cycles, ABORT=1 for 1 cycle, then REL, then re-grant to REQ1 (REQ0 idle).
- TIMEOUT=8, DONE1 asserted on the 8th owned cycle -> normal release, ABORT stays 0.
- RST asserted mid-OWN0 between clock edges -> GNT0, BUSY and ZF0 drop immediately, opcode=000. After RST release with REQ1=1 -> GNT1 after one edge.
- REQ0 owning while REQ1 toggles and OPC1 changes every cycle -> datapath outputs show only the OPC0/OPA0/OPB0 values, and GNT1 stays 0 throughout.

Source files
------------

// File: rtl/dp_arbiter.sv
// Round-robin owner arbiter for the shared 4-register ALU datapath.
// Grants whole-program ownership, forces a NOP cycle on every hand-over and revokes stuck owners.
module dp_arbiter #(
    parameter int TIMEOUT = 64,
    parameter int OPC_W   = 3,
    parameter int REG_W   = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             REQ0,
    input  logic             REQ1,
    input  logic             DONE0,
    input  logic             DONE1,
    input  logic [OPC_W-1:0] OPC0,
    input  logic [OPC_W-1:0] OPC1,
    input  logic [REG_W-1:0] OPA0,
    input  logic [REG_W-1:0] OPA1,
    input  logic [REG_W-1:0] OPB0,
    input  logic [REG_W-1:0] OPB1,
    input  logic             ZERO_FLAG,
    output logic             GNT0,
    output logic             GNT1,
    output logic             ZF0,
    output logic             ZF1,
    output logic [OPC_W-1:0] opcode,
    output logic [REG_W-1:0] operand1,
    output logic [REG_W-1:0] operand2,
    output logic             BUSY,
    output logic             ABORT
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2,
        REL  = 2'd3
    } state_t;

    localparam int          TO_LAST_I = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
    localparam logic [15:0] TO_LAST   = TO_LAST_I[15:0];
    localparam bit          WD_EN     = (TIMEOUT != 0);

    state_t      state_q, state_d;
    logic        last_q, last_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  gnt_q, gnt_d;
    logic        busy_q, busy_d;
    logic        abort_q, abort_d;
    logic        wd_hit;

    // State register plus registered output decodes; async reset drops the grant at once.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            cnt_q   <= 16'd0;
            gnt_q   <= 2'b00;
            busy_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            busy_q  <= busy_d;
            abort_q <= abort_d;
        end
    end

    assign wd_hit = WD_EN && (cnt_q == TO_LAST);

    // Next-state: arbitration in IDLE/REL, release and watchdog in OWNx.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        abort_d = 1'b0;
        unique case (state_q)
            IDLE, REL: begin
                if (REQ0 && REQ1)  state_d = last_q ? OWN0 : OWN1;
                else if (REQ0)     state_d = OWN0;
                else if (REQ1)     state_d = OWN1;
                else               state_d = IDLE;
            end
            OWN0: begin
                if (DONE0 || !REQ0) begin
                    state_d = REL;
                    last_d  = 1'b0;
                end else if (wd_hit) begin
                    state_d = REL;
                    last_d  = 1'b0;
                    abort_d = 1'b1;
                end
            end
            OWN1: begin
                if (DONE1 || !REQ1) begin
                    state_d = REL;
                    last_d  = 1'b1;
                end else if (wd_hit) begin
                    state_d = REL;
                    last_d  = 1'b1;
                    abort_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        gnt_d  = {state_d == OWN1, state_d == OWN0};
        busy_d = |gnt_d;

        // Owners never go straight OWN0<->OWN1, so "stay in OWN" equals "same owner".
        if ((state_q == OWN0 || state_q == OWN1) && state_d == state_q)
            cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
        else
            cnt_d = 16'd0;
    end

    // Output decode: datapath mux keyed off the registered grant, never mixing fields.
    always_comb begin
        opcode   = '0;
        operand1 = '0;
        operand2 = '0;
        if (gnt_q[0]) begin
            opcode   = OPC0;
            operand1 = OPA0;
            operand2 = OPB0;
        end else if (gnt_q[1]) begin
            opcode   = OPC1;
            operand1 = OPA1;
            operand2 = OPB1;
        end
        GNT0  = gnt_q[0];
        GNT1  = gnt_q[1];
        ZF0   = gnt_q[0] & ZERO_FLAG;
        ZF1   = gnt_q[1] & ZERO_FLAG;
        BUSY  = busy_q;
        ABORT = abort_q;
    end

endmodule

// File: tb/tb_dp_arbiter.sv
// Directed self-checking bench for dp_arbiter with an 8-cycle watchdog.
module tb_dp_arbiter;

    logic       CLK = 1'b0;
    logic       RST;
    logic       REQ0, REQ1, DONE0, DONE1, ZERO_FLAG;
    logic [2:0] OPC0, OPC1;
    logic [1:0] OPA0, OPA1, OPB0, OPB1;
    logic       GNT0, GNT1, ZF0, ZF1, BUSY, ABORT;
    logic [2:0] opcode;
    logic [1:0] operand1, operand2;

    int checks   = 0;
    int failures = 0;

    dp_arbiter #(.TIMEOUT(8), .OPC_W(3), .REG_W(2)) dut (
        .CLK(CLK), .RST(RST),
        .REQ0(REQ0), .REQ1(REQ1), .DONE0(DONE0), .DONE1(DONE1),
        .OPC0(OPC0), .OPC1(OPC1), .OPA0(OPA0), .OPA1(OPA1),
        .OPB0(OPB0), .OPB1(OPB1), .ZERO_FLAG(ZERO_FLAG),
        .GNT0(GNT0), .GNT1(GNT1), .ZF0(ZF0), .ZF1(ZF1),
        .opcode(opcode), .operand1(operand1), .operand2(operand2),
        .BUSY(BUSY), .ABORT(ABORT)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        check({tag, " gnt"}, {GNT1, GNT0}, 2'b00);
        check({tag, " busy"}, BUSY, 1'b0);
        check({tag, " opc"}, {opcode, operand1, operand2}, 7'd0);
        check({tag, " zf"}, {ZF1, ZF0}, 2'b00);
    endtask

    initial begin
        RST = 1'b1; REQ0 = 0; REQ1 = 0; DONE0 = 0; DONE1 = 0; ZERO_FLAG = 0;
        OPC0 = 0; OPC1 = 0; OPA0 = 0; OPA1 = 0; OPB0 = 0; OPB1 = 0;
        #3;
        chk_idle("reset");
        check("reset abort", ABORT, 1'b0);
        tick();
        RST = 1'b0;

        // single requester 0, pass-through and zero-flag routing
        REQ0 = 1; OPC0 = 3'b100; OPA0 = 2'b11; OPB0 = 2'b00; ZERO_FLAG = 1;
        OPC1 = 3'b111; OPA1 = 2'b01; OPB1 = 2'b10;
        #1;
        check("t1 pre-edge gnt0", GNT0, 1'b0);
        tick();
        check("t1 gnt", {GNT1, GNT0}, 2'b01);
        check("t1 opcode", opcode, 3'b100);
        check("t1 operands", {operand1, operand2}, 4'b1100);
        check("t1 busy", BUSY, 1'b1);
        check("t1 zf", {ZF1, ZF0}, 2'b01);
        ZERO_FLAG = 0; #1;
        check("t1 zf follow", ZF0, 1'b0);
        DONE0 = 1; REQ0 = 0;
        tick();
        chk_idle("t1 rel");
        DONE0 = 0;
        tick();
        chk_idle("t1 idle");

        // contention right after reset, then alternation
        RST = 1; #1; RST = 0;
        REQ0 = 1; REQ1 = 1; OPC0 = 3'b010; OPC1 = 3'b101; ZERO_FLAG = 1;
        tick();
        check("t2 first gnt", {GNT1, GNT0}, 2'b01);
        check("t2 opc0", opcode, 3'b010);
        DONE0 = 1;
        tick();
        chk_idle("t2 rel");
        DONE0 = 0;
        tick();
        check("t2 gnt1", {GNT1, GNT0}, 2'b10);
        check("t2 opc1", opcode, 3'b101);
        check("t2 zf1", {ZF1, ZF0}, 2'b10);
        DONE1 = 1;
        tick();
        check("t2 rel2 gnt", {GNT1, GNT0}, 2'b00);
        check("t2 rel2 opc", opcode, 3'b000);
        DONE1 = 0;
        tick();
        check("t2 alternate gnt0", {GNT1, GNT0}, 2'b01);
        REQ0 = 0; REQ1 = 0;
        tick();
        tick();
        chk_idle("t2 idle");

        // watchdog: REQ1 held without DONE1
        REQ1 = 1;
        tick();
        for (int i = 1; i <= 8; i++) begin
            check($sformatf("t3 held c%0d", i), {ABORT, GNT1}, 2'b01);
            if (i < 8) tick();
        end
        tick();
        check("t3 abort gnt", {GNT1, GNT0, BUSY}, 3'b000);
        check("t3 abort pulse", ABORT, 1'b1);
        check("t3 abort opc", opcode, 3'b000);
        tick();
        check("t3 regrant", {GNT1, GNT0}, 2'b10);
        check("t3 abort one cycle", ABORT, 1'b0);
        REQ1 = 0;
        tick();
        tick();
        chk_idle("t3 idle");

        // DONE1 on the 8th owned cycle beats the watchdog
        REQ1 = 1;
        tick();
        for (int i = 1; i < 8; i++) tick();
        check("t4 cycle8 gnt", GNT1, 1'b1);
        DONE1 = 1;
        tick();
        check("t4 rel gnt", GNT1, 1'b0);
        check("t4 no abort", ABORT, 1'b0);
        DONE1 = 0; REQ1 = 0;
        tick();
        tick();

        // async reset mid-ownership
        REQ0 = 1; OPC0 = 3'b110; ZERO_FLAG = 1;
        tick();
        check("t5 own0", {GNT0, opcode}, {1'b1, 3'b110});
        #2; RST = 1; #1;
        chk_idle("t5 async rst");
        REQ0 = 0; REQ1 = 1; OPC1 = 3'b011;
        #1; RST = 0;
        tick();
        check("t5 gnt1 after rst", {GNT1, GNT0}, 2'b10);
        check("t5 opc1", opcode, 3'b011);
        REQ1 = 0;
        tick();
        tick();

        // non-owner noise must never reach the datapath
        REQ0 = 1; OPC0 = 3'b011; OPA0 = 2'b01; OPB0 = 2'b10;
        tick();
        for (int i = 0; i < 5; i++) begin
            REQ1 = i[0];
            OPC1 = 3'(i + 4); OPA1 = 2'(i); OPB1 = 2'(i + 1);
            #1;
            check($sformatf("t6 dp c%0d", i), {opcode, operand1, operand2}, {3'b011, 2'b01, 2'b10});
            check($sformatf("t6 gnt c%0d", i), {GNT1, ZF1}, 2'b00);
            tick();
        end
        REQ0 = 0; REQ1 = 0;
        tick();
        chk_idle("t6 rel");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
